// File: rtl/seg_deserializer_if.sv
// Serial segment lanes plus shift clock in, rebuilt per-digit patterns and frame status out.
interface seg_deserializer_if #(
    parameter int DIGITS = 4
);
    logic [DIGITS-1:0]   seg_in;
    logic                shift_in;
    logic [8*DIGITS-1:0] seg_pattern;
    logic [4*DIGITS-1:0] digit_val;
    logic [DIGITS-1:0]   digit_err;
    logic                frame_valid;
    logic                frame_err;
    logic [7:0]          frame_cnt;

    modport master (
        output seg_in, shift_in,
        input  seg_pattern, digit_val, digit_err, frame_valid, frame_err, frame_cnt
    );

    modport slave (
        input  seg_in, shift_in,
        output seg_pattern, digit_val, digit_err, frame_valid, frame_err, frame_cnt
    );
endinterface

// File: rtl/seg_deserializer.sv
// Rebuilds 8-bit 7-segment patterns from per-digit serial lanes, decodes them to hex,
// and discards partial frames after IDLE_CYCLES clocks without a shift edge.
module seg_deserializer #(
    parameter int DIGITS      = 4,
    parameter int IDLE_CYCLES = 64
) (
    input logic               clk,
    input logic               reset,
    seg_deserializer_if.slave bus
);
    localparam int            TW        = $clog2(IDLE_CYCLES + 1);
    localparam logic [TW-1:0] TIMER_MAX = TW'(IDLE_CYCLES);

    typedef enum logic {IDLE, RECEIVING} rx_state_e;

    // Returns {err, val}; an unknown glyph decodes to value 0 with err set.
    function automatic logic [4:0] decode_glyph(input logic [6:0] p);
        case (p)
            7'h3F:   decode_glyph = 5'h00;
            7'h06:   decode_glyph = 5'h01;
            7'h5B:   decode_glyph = 5'h02;
            7'h4F:   decode_glyph = 5'h03;
            7'h66:   decode_glyph = 5'h04;
            7'h6D:   decode_glyph = 5'h05;
            7'h7D:   decode_glyph = 5'h06;
            7'h07:   decode_glyph = 5'h07;
            7'h7F:   decode_glyph = 5'h08;
            7'h6F:   decode_glyph = 5'h09;
            7'h77:   decode_glyph = 5'h0A;
            7'h7C:   decode_glyph = 5'h0B;
            7'h39:   decode_glyph = 5'h0C;
            7'h5E:   decode_glyph = 5'h0D;
            7'h79:   decode_glyph = 5'h0E;
            7'h71:   decode_glyph = 5'h0F;
            default: decode_glyph = 5'h10;
        endcase
    endfunction

    logic [DIGITS-1:0]      seg_s1, seg_s2;
    logic                   shift_s1, shift_s2, shift_s3;
    logic                   shift_edge;
    logic [DIGITS-1:0][7:0] sr_q, sr_d;
    logic [2:0]             bit_cnt_q, bit_cnt_d;
    logic [TW-1:0]          timer_q, timer_d;
    logic [DIGITS-1:0][7:0] pattern_q, pattern_d;
    logic [DIGITS-1:0][3:0] val_q, val_d;
    logic [DIGITS-1:0]      err_q, err_d;
    logic                   valid_q, valid_d;
    logic                   ferr_q, ferr_d;
    logic [7:0]             cnt_q, cnt_d;
    rx_state_e              state;

    assign shift_edge = shift_s2 & ~shift_s3;
    assign state      = (bit_cnt_q == 3'd0) ? IDLE : RECEIVING;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            seg_s1   <= '0;
            seg_s2   <= '0;
            shift_s1 <= 1'b0;
            shift_s2 <= 1'b0;
            shift_s3 <= 1'b0;
        end else begin
            // NOTE: non-blocking so each stage takes the previous stage's pre-edge value; blocking would collapse the chain.
            seg_s1   <= bus.seg_in;
            seg_s2   <= seg_s1;
            shift_s1 <= bus.shift_in;
            shift_s2 <= shift_s1;
            shift_s3 <= shift_s2;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sr_q      <= '0;
            bit_cnt_q <= '0;
            timer_q   <= '0;
            pattern_q <= '0;
            val_q     <= '0;
            err_q     <= '0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
            cnt_q     <= '0;
        end else begin
            sr_q      <= sr_d;
            bit_cnt_q <= bit_cnt_d;
            timer_q   <= timer_d;
            pattern_q <= pattern_d;
            val_q     <= val_d;
            err_q     <= err_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
            cnt_q     <= cnt_d;
        end
    end

    always_comb begin
        // NOTE: every signal driven here gets a default first; any path that skipped one would infer a latch.
        sr_d      = sr_q;
        bit_cnt_d = bit_cnt_q;
        timer_d   = timer_q;
        pattern_d = pattern_q;
        val_d     = val_q;
        err_d     = err_q;
        valid_d   = 1'b0;
        ferr_d    = 1'b0;
        cnt_d     = cnt_q;

        if (shift_edge) begin
            // A detected edge always wins over a coincident timeout.
            timer_d   = '0;
            bit_cnt_d = bit_cnt_q + 3'd1;
            for (int j = 0; j < DIGITS; j++) begin
                sr_d[j] = {sr_q[j][6:0], seg_s2[j]};
            end
            if (bit_cnt_q == 3'd7) begin
                pattern_d = sr_d;
                for (int j = 0; j < DIGITS; j++) begin
                    {err_d[j], val_d[j]} = decode_glyph(sr_d[j][6:0]);
                end
                valid_d = 1'b1;
                cnt_d   = cnt_q + 8'd1;
            end
        end else if (timer_q != TIMER_MAX) begin
            timer_d = timer_q + TW'(1);
        end else if (state == RECEIVING) begin
            bit_cnt_d = '0;
            ferr_d    = 1'b1;
        end
    end

    assign bus.seg_pattern = pattern_q;
    assign bus.digit_val   = val_q;
    assign bus.digit_err   = err_q;
    assign bus.frame_valid = valid_q;
    assign bus.frame_err   = ferr_q;
    assign bus.frame_cnt   = cnt_q;
endmodule

// File: doc/seg_deserializer.md
# seg_deserializer

Serial-to-parallel receiver for the 7-segment output stream produced by the counter's display serializer: one serial segment lane per digit plus a shared shift clock. The block sits directly downstream of that serializer, on the board-side display path or in a loopback self-check. It samples the stream on the system clock and rebuilds each digit's 8-bit segment pattern. It then decodes each pattern back to a 4-bit hex value and flags malformed or truncated frames.

## Interface
- DIGITS, 4, number of digit lanes.
- IDLE_CYCLES, 64, clk cycles without a shift edge before a partial frame is discarded; must be ≥ 2.

- clk  in  1  system clock (1 MHz nominal).
- reset  in  1  asynchronous, active-high; clears all state.
- seg_in  in  DIGITS  serial segment data, one lane per digit; lane j carries digit j.
- shift_in  in  1  shift clock; data is taken on its rising edge.
- seg_pattern  out  8*DIGITS  last complete frame; digit j at [8*j+:8], bit order {dp,g,f,e,d,c,b,a}, active high.
- digit_val  out  4*DIGITS  decoded hex value per digit, at [4*j+:4].
- digit_err  out  DIGITS  1 = pattern of digit j (dp masked) matches no hex glyph; the matching digit_val is 0.
- frame_valid  out  1  one-cycle pulse when a complete frame is latched.
- frame_err  out  1  one-cycle pulse when a partial frame is discarded by timeout.
- frame_cnt  out  8  count of complete frames; wraps 255→0.

## Operation
- Synchronizer: seg_in and shift_in each pass through 2 flops (s1, s2). A third flop s3 on shift_in gives edge = s2 & ~s3.
- Frame: 8 bits per lane, MSB (dp) first. Each edge left-shifts s2(seg_in[j]) into the 8-bit shift register of lane j.
- bit_cnt (3 bits) counts edges within a frame. On the edge where bit_cnt==7:
  - seg_pattern ← {sr[6:0], new bit} for each lane.
  - digit_val and digit_err are updated from the same pattern in the same clock.
  - frame_valid fires; frame_cnt increments; bit_cnt → 0.
- Glyph table (pattern & 0x7F): 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71. Any other value sets digit_err.
- Idle timer: cleared on every edge; otherwise increments and saturates at IDLE_CYCLES.
- Timeout: when the timer reaches IDLE_CYCLES with bit_cnt≠0:
  - bit_cnt → 0 and frame_err fires.
  - Shift registers are left as they are. seg_pattern, digit_val and frame_cnt are unchanged.
- With bit_cnt==0 the timer saturates silently and frame_err does not fire.
- Simultaneous edge and timeout in the same cycle: the edge wins. The bit is counted, the timer clears and there is no frame_err.
- States are implicit: IDLE (bit_cnt==0) and RECEIVING (bit_cnt 1..7).

## Timing
- Reset: all outputs 0. Shift registers, synchronizers, bit_cnt and timer are 0. The timer is 0 after reset, so no spurious frame_err is generated.
- Reset asserted mid-frame discards the partial frame immediately; the first edge after release is bit 0.
- Latency: shift_in rises before clk edge k → the shift happens at edge k+2.
  - 8th edge → seg_pattern, digit_val, digit_err and frame_cnt are updated at edge k+2.
  - frame_valid is high for the single cycle following edge k+2.
- Data setup: seg_in must be stable from one clk period before the shift_in rise until one clk period after it. The same 2-flop delay keeps data and edge aligned.
- The minimum shift_in high and low times are 2 clk periods each; faster edges can be missed.
- Timeout: frame_err is high for one cycle, IDLE_CYCLES+1 clk edges after the last shift edge was detected.
- Back-to-back frames: no gap is required. Bit 0 of the next frame may arrive on the edge following the frame-completing edge.

## Test plan
- Reset, then serially send one frame with lanes 0..3 = 3F, 06, 5B, 4F (MSB first, 4 clk per half-period) → frame_valid pulses once; seg_pattern=0x4F5B063F; digit_val=0x3210; digit_err=0; frame_cnt=1.
- Send lane 0 = 0xBF (dp set) and lane 1 = 0x00 → digit_val[3:0]=0 with digit_err[0]=0; digit_err[1]=1 with digit_val[7:4]=0.
- Send 5 bits, then idle 100 clk → frame_err pulses exactly once at 65 clk edges after the 5th edge was detected; outputs are unchanged. A following full frame of 71,79,5E,39 decodes to 0xCDEF.
- Send 256 consecutive frames back-to-back → 256 frame_valid pulses; frame_cnt wraps to 0.
- Assert reset after the 3rd bit of a frame and release it → all outputs 0. A subsequent full frame decodes correctly, with no frame_err.
- Set IDLE_CYCLES=8 and place the 2nd edge so that it is detected exactly when the timer reaches 8 → no frame_err; the frame completes normally.
